// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - TileLink-UL opcodes and response slot type shared by the source pool master
//
// Purpose : A/D channel opcode constants and the per-source response slot record.
// Ports   : none (package).

package tl_ul_pkg;

    // Width of the data field held in a response slot; the master's DATA_BITS defaults to this.
    localparam int TL_DATA_BITS = 32;

    // A-channel opcodes
    localparam logic [2:0] GET      = 3'd4;
    localparam logic [2:0] PUT_FULL = 3'd0;

    // D-channel opcodes
    localparam logic [2:0] ACK      = 3'd0;
    localparam logic [2:0] ACK_DATA = 3'd1;

    // One buffered D beat, waiting for its turn in request order
    typedef struct packed {
        logic [2:0]              opcode;
        logic [TL_DATA_BITS-1:0] data;
        logic                    error;
    } d_slot_t;

endpackage

// File: rtl/tl_ul_source_pool_master_if.sv
// rtl/tl_ul_source_pool_master_if.sv - client request/response, TL-UL A/D and status bundle
//
// Purpose : groups the client stream, the A and D channels and proto_err.
// Modports: master - the issue stage (drives req_ready, resp_*, a_*, d_ready, proto_err)
//           slave  - the client plus downstream link (drives the opposite directions)

interface tl_ul_source_pool_master_if #(
    parameter int SOURCE_BITS = 1,
    parameter int ADDR_BITS   = 9,
    parameter int DATA_BITS   = 32,
    parameter int SINK_BITS   = 2
);
    localparam int MASK_BITS = DATA_BITS / 8;

    // client request
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [DATA_BITS-1:0]   req_data;
    logic [MASK_BITS-1:0]   req_mask;

    // client response
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DATA_BITS-1:0]   resp_data;
    logic                   resp_error;

    // A channel
    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [2:0]             a_param;
    logic [2:0]             a_size;
    logic [SOURCE_BITS-1:0] a_source;
    logic [ADDR_BITS-1:0]   a_address;
    logic [MASK_BITS-1:0]   a_mask;
    logic [DATA_BITS-1:0]   a_data;

    // D channel
    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [SOURCE_BITS-1:0] d_source;
    logic [SINK_BITS-1:0]   d_sink;
    logic                   d_denied;
    logic                   d_corrupt;
    logic [DATA_BITS-1:0]   d_data;

    // status
    logic                   proto_err;

    modport master (
        input  req_valid, req_write, req_addr, req_data, req_mask,
        output req_ready,
        output resp_valid, resp_data, resp_error,
        input  resp_ready,
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_source, d_sink, d_denied, d_corrupt, d_data,
        output d_ready,
        output proto_err
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data, req_mask,
        input  req_ready,
        input  resp_valid, resp_data, resp_error,
        output resp_ready,
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_source, d_sink, d_denied, d_corrupt, d_data,
        input  d_ready,
        input  proto_err
    );

endinterface

// File: rtl/tl_src_alloc.sv
// rtl/tl_src_alloc.sv - lowest-free source ID priority encoder
//
// Purpose : picks the lowest-numbered ID whose inflight bit is clear.
// Ports   : inflight (in)  - one bit per source ID, 1 = in use
//           free_any (out) - at least one ID is free
//           free_id  (out) - lowest free ID (0 when none is free)

module tl_src_alloc #(
    parameter int SOURCE_BITS = 1
) (
    input  logic [(1<<SOURCE_BITS)-1:0] inflight,
    output logic                        free_any,
    output logic [SOURCE_BITS-1:0]      free_id
);

    localparam int NID = 1 << SOURCE_BITS;

    always_comb begin
        free_any = ~&inflight;
        free_id  = '0;
        // Scan high to low so the last hit, the lowest free index, wins.
        for (int i = NID - 1; i >= 0; i--) begin
            if (!inflight[i]) begin
                free_id = SOURCE_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/tl_ul_source_pool_master.sv
// rtl/tl_ul_source_pool_master.sv - TL-UL issue stage with source pool and in-order response return
//
// Purpose : turns client read/write requests into A beats, allocates source IDs from a pool,
//           buffers D beats per source and hands responses back in request order.
// Ports   : clock, reset (sync, active-high)
//           bus (master modport) - client req/resp streams, A and D channels, sticky proto_err

module tl_ul_source_pool_master
    import tl_ul_pkg::*;
#(
    parameter int SOURCE_BITS = 1,
    parameter int ADDR_BITS   = 9,
    parameter int DATA_BITS   = TL_DATA_BITS,
    parameter int SINK_BITS   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    tl_ul_source_pool_master_if.master   bus
);

    localparam int NID       = 1 << SOURCE_BITS;
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int SIZE_LOG2 = $clog2(MASK_BITS);

    // source pool and per-source response slots
    logic [NID-1:0]         r_inflight;
    logic [NID-1:0]         r_slot_full;
    d_slot_t                r_slot [NID];

    // order FIFO of allocated IDs
    logic [SOURCE_BITS-1:0] r_fifo [NID];
    logic [SOURCE_BITS-1:0] r_wptr;
    logic [SOURCE_BITS-1:0] r_rptr;
    logic [SOURCE_BITS:0]   r_count;

    // registered A beat
    logic                   r_a_valid;
    logic [2:0]             r_a_opcode;
    logic [SOURCE_BITS-1:0] r_a_source;
    logic [ADDR_BITS-1:0]   r_a_address;
    logic [MASK_BITS-1:0]   r_a_mask;
    logic [DATA_BITS-1:0]   r_a_data;

    logic                   r_proto_err;

    logic                   w_free_any;
    logic [SOURCE_BITS-1:0] w_free_id;
    logic [SOURCE_BITS-1:0] w_head;
    logic                   w_fifo_full;
    logic                   w_req_ready;
    logic                   w_accept;
    logic                   w_a_fire;
    logic                   w_resp_valid;
    logic                   w_pop;
    logic                   w_d_opc_ok;
    logic                   w_d_legal;
    logic                   w_d_store;
    logic [NID-1:0]         w_inflight_nxt;
    logic [NID-1:0]         w_slot_full_nxt;
    d_slot_t                w_head_slot;
    logic                   w_unused;

    tl_src_alloc #(
        .SOURCE_BITS (SOURCE_BITS)
    ) u_alloc (
        .inflight (r_inflight),
        .free_any (w_free_any),
        .free_id  (w_free_id)
    );

    assign w_head       = r_fifo[r_rptr];
    assign w_fifo_full  = (r_count == (SOURCE_BITS+1)'(NID));
    assign w_req_ready  = !r_a_valid && w_free_any && !w_fifo_full;
    assign w_accept     = bus.req_valid && w_req_ready;
    assign w_a_fire     = r_a_valid && bus.a_ready;
    assign w_resp_valid = (r_count != '0) && r_slot_full[w_head];
    assign w_pop        = w_resp_valid && bus.resp_ready;
    assign w_head_slot  = r_slot[w_head];

    // A beat for the ID being popped this cycle always sees a full slot, so the
    // explicit same-ID term only documents that such a beat is rejected.
    assign w_d_opc_ok = (bus.d_opcode == ACK) || (bus.d_opcode == ACK_DATA);
    assign w_d_legal  = r_inflight[bus.d_source] && !r_slot_full[bus.d_source] && w_d_opc_ok &&
                        !(w_pop && (bus.d_source == w_head));
    assign w_d_store  = bus.d_valid && w_d_legal;

    // The freed ID is cleared here but allocation reads r_inflight, so it is
    // not handed out again until the following cycle.
    always_comb begin
        w_inflight_nxt  = r_inflight;
        w_slot_full_nxt = r_slot_full;
        if (w_pop) begin
            w_inflight_nxt[w_head]  = 1'b0;
            w_slot_full_nxt[w_head] = 1'b0;
        end
        if (w_accept) begin
            w_inflight_nxt[w_free_id] = 1'b1;
        end
        if (w_d_store) begin
            w_slot_full_nxt[bus.d_source] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight  <= '0;
            r_slot_full <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_a_valid   <= 1'b0;
            r_a_opcode  <= '0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_inflight  <= w_inflight_nxt;
            r_slot_full <= w_slot_full_nxt;

            if (w_a_fire) begin
                r_a_valid <= 1'b0;
            end

            // req_ready requires !a_valid, so an accept never coincides with an A handshake.
            if (w_accept) begin
                r_a_valid       <= 1'b1;
                r_a_opcode      <= bus.req_write ? PUT_FULL : GET;
                r_a_source      <= w_free_id;
                r_a_address     <= bus.req_addr;
                r_a_mask        <= bus.req_write ? bus.req_mask : '1;
                r_a_data        <= bus.req_write ? bus.req_data : '0;
                r_fifo[r_wptr]  <= w_free_id;
                r_wptr          <= r_wptr + 1'b1;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_d_store) begin
                r_slot[bus.d_source] <= '{opcode: bus.d_opcode,
                                          data:   bus.d_data,
                                          error:  bus.d_denied | bus.d_corrupt};
            end

            if (bus.d_valid && !w_d_legal) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    // AccessAck carries no payload; the client sees zero data for writes.
    assign bus.resp_data  = (w_head_slot.opcode == ACK_DATA) ? w_head_slot.data : '0;
    assign bus.resp_error = w_head_slot.error;

    assign bus.a_valid    = r_a_valid;
    assign bus.a_opcode   = r_a_opcode;
    assign bus.a_param    = 3'd0;
    assign bus.a_size     = 3'(SIZE_LOG2);
    assign bus.a_source   = r_a_source;
    assign bus.a_address  = r_a_address;
    assign bus.a_mask     = r_a_mask;
    assign bus.a_data     = r_a_data;

    assign bus.d_ready    = 1'b1;
    assign bus.proto_err  = r_proto_err;

    // d_sink is carried on the link but has no meaning to this master.
    assign w_unused = ^bus.d_sink;

endmodule

// File: tb/tb_tl_ul_source_pool_master.sv
// tb/tb_tl_ul_source_pool_master.sv - directed and randomized checks of the source pool master

module tb_tl_ul_source_pool_master;
    import tl_ul_pkg::*;

    localparam int SB  = 1;
    localparam int AB  = 9;
    localparam int DB  = 32;
    localparam int KB  = 2;
    localparam int MB  = DB / 8;
    localparam int NID = 1 << SB;

    logic clock = 1'b0;
    logic reset = 1'b1;

    tl_ul_source_pool_master_if #(.SOURCE_BITS(SB), .ADDR_BITS(AB), .DATA_BITS(DB), .SINK_BITS(KB)) bus ();

    tl_ul_source_pool_master #(
        .SOURCE_BITS (SB),
        .ADDR_BITS   (AB),
        .DATA_BITS   (DB),
        .SINK_BITS   (KB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_mask   = '0;
        bus.resp_ready = 1'b0;
        bus.a_ready    = 1'b0;
        bus.d_valid    = 1'b0;
        bus.d_opcode   = '0;
        bus.d_source   = '0;
        bus.d_sink     = '0;
        bus.d_denied   = 1'b0;
        bus.d_corrupt  = 1'b0;
        bus.d_data     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send(input logic wr, input logic [AB-1:0] addr, input logic [DB-1:0] data,
                        input logic [MB-1:0] mask);
        chk("send_req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_mask  = mask;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [SB-1:0] src, input logic [2:0] opc, input logic [DB-1:0] data,
                          input logic den);
        bus.d_valid  = 1'b1;
        bus.d_source = src;
        bus.d_opcode = opc;
        bus.d_data   = data;
        bus.d_denied = den;
        bus.d_sink   = KB'($urandom);
        tick();
        bus.d_valid  = 1'b0;
        bus.d_denied = 1'b0;
    endtask

    // reference model state
    bit          m_busy  [NID];
    bit          m_got   [NID];
    bit          m_wr    [NID];
    logic [DB-1:0] m_rdata [NID];
    bit          m_rerr  [NID];
    int          q [$];
    int          cand [$];
    bit          m_apend;
    logic [48:0] m_abeat;
    bit          m_perr;

    initial begin
        int  free_id;
        int  ds;
        int  h;
        bit  exp_rr, exp_rv, acc, fire, pop, legal;

        idle();
        do_reset();

        // reset state
        chk("rst_a_valid",    64'(bus.a_valid), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_d_ready",    64'(bus.d_ready), 64'd1);
        chk("rst_req_ready",  64'(bus.req_ready), 64'd1);
        chk("rst_proto_err",  64'(bus.proto_err), 64'd0);
        chk("rst_a_payload",  64'({bus.a_opcode, bus.a_source, bus.a_address, bus.a_mask, bus.a_data}), 64'd0);

        // Get to 0x040, answered with AccessAckData
        send(1'b0, 9'h040, 32'h0, 4'h0);
        chk("get_a_valid",   64'(bus.a_valid), 64'd1);
        chk("get_a_opcode",  64'(bus.a_opcode), 64'(GET));
        chk("get_a_source",  64'(bus.a_source), 64'd0);
        chk("get_a_mask",    64'(bus.a_mask), 64'hF);
        chk("get_a_address", 64'(bus.a_address), 64'h040);
        chk("get_a_size",    64'(bus.a_size), 64'd2);
        chk("get_a_param",   64'(bus.a_param), 64'd0);
        chk("get_req_busy",  64'(bus.req_ready), 64'd0);
        bus.a_ready = 1'b1;
        tick();
        bus.a_ready = 1'b0;
        chk("get_a_drop",    64'(bus.a_valid), 64'd0);
        d_beat(1'b0, ACK_DATA, 32'hDEADBEEF, 1'b0);
        chk("get_resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("get_resp_data",  64'(bus.resp_data), 64'hDEADBEEF);
        chk("get_resp_error", 64'(bus.resp_error), 64'd0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk("get_resp_done",  64'(bus.resp_valid), 64'd0);

        // two Puts with a_ready high: sources 0 then 1, pool exhausted
        bus.a_ready = 1'b1;
        send(1'b1, 9'h000, 32'h1111_0000, 4'hF);
        chk("put0_a_source", 64'(bus.a_source), 64'd0);
        chk("put0_a_opcode", 64'(bus.a_opcode), 64'(PUT_FULL));
        tick();
        chk("put0_a_drop",   64'(bus.a_valid), 64'd0);
        send(1'b1, 9'h004, 32'h2222_0004, 4'h3);
        chk("put1_a_source", 64'(bus.a_source), 64'd1);
        chk("put1_a_mask",   64'(bus.a_mask), 64'h3);
        chk("put1_a_data",   64'(bus.a_data), 64'h2222_0004);
        tick();
        bus.a_ready = 1'b0;
        chk("pool_full_req_ready", 64'(bus.req_ready), 64'd0);

        // out-of-order D: src1 first is held until src0 arrives
        d_beat(1'b1, ACK, 32'h0, 1'b0);
        chk("ooo_hold_resp",  64'(bus.resp_valid), 64'd0);
        d_beat(1'b0, ACK, 32'h5555_AAAA, 1'b1);
        chk("ooo_first_valid", 64'(bus.resp_valid), 64'd1);
        chk("ooo_first_error", 64'(bus.resp_error), 64'd1);
        chk("ooo_first_data",  64'(bus.resp_data), 64'd0);
        bus.resp_ready = 1'b1;
        tick();
        chk("ooo_second_valid", 64'(bus.resp_valid), 64'd1);
        chk("ooo_second_error", 64'(bus.resp_error), 64'd0);
        tick();
        bus.resp_ready = 1'b0;
        chk("ooo_drained",    64'(bus.resp_valid), 64'd0);
        chk("ooo_proto_err",  64'(bus.proto_err), 64'd0);
        chk("ooo_req_ready",  64'(bus.req_ready), 64'd1);

        // illegal D beats: unallocated source, bad opcode
        bus.a_ready = 1'b1;
        send(1'b0, 9'h080, 32'h0, 4'h0);
        tick();
        bus.a_ready = 1'b0;
        d_beat(1'b1, ACK, 32'h0, 1'b0);
        chk("perr_set",       64'(bus.proto_err), 64'd1);
        chk("perr_no_resp",   64'(bus.resp_valid), 64'd0);
        d_beat(1'b0, 3'd2, 32'hBAD0BAD0, 1'b0);
        chk("perr_badop_resp", 64'(bus.resp_valid), 64'd0);
        tick();
        chk("perr_sticky",    64'(bus.proto_err), 64'd1);
        d_beat(1'b0, ACK_DATA, 32'h1234_5678, 1'b0);
        chk("perr_legal_valid", 64'(bus.resp_valid), 64'd1);
        chk("perr_legal_data",  64'(bus.resp_data), 64'h1234_5678);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;

        // A back-pressure: beat stable while a_ready is low
        send(1'b1, 9'h1FC, 32'hA5A5_5A5A, 4'h5);
        for (int i = 0; i < 5; i++) begin
            chk("stall_a_valid", 64'(bus.a_valid), 64'd1);
            chk("stall_a_beat",
                64'({bus.a_opcode, bus.a_source, bus.a_address, bus.a_mask, bus.a_data}),
                64'({PUT_FULL, 1'b0, 9'h1FC, 4'h5, 32'hA5A5_5A5A}));
            if (i < 4) tick();
        end
        bus.a_ready = 1'b1;
        tick();
        bus.a_ready = 1'b0;
        chk("stall_a_drop", 64'(bus.a_valid), 64'd0);
        d_beat(1'b0, ACK, 32'h0, 1'b0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;

        // reset with both IDs inflight
        bus.a_ready = 1'b1;
        send(1'b0, 9'h100, 32'h0, 4'h0);
        tick();
        send(1'b0, 9'h104, 32'h0, 4'h0);
        tick();
        bus.a_ready = 1'b0;
        chk("prerst_req_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_req_ready",  64'(bus.req_ready), 64'd1);
        chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("midrst_proto_err",  64'(bus.proto_err), 64'd0);
        send(1'b0, 9'h108, 32'h0, 4'h0);
        chk("midrst_a_source",   64'(bus.a_source), 64'd0);

        // randomized traffic against a queue-based model
        for (int round = 0; round < 4; round++) begin
            idle();
            do_reset();
            q.delete();
            for (int k = 0; k < NID; k++) begin
                m_busy[k] = 1'b0;
                m_got[k]  = 1'b0;
            end
            m_apend = 1'b0;
            m_perr  = 1'b0;
            m_abeat = '0;

            for (int c = 0; c < 150; c++) begin
                free_id = -1;
                for (int k = NID - 1; k >= 0; k--) if (!m_busy[k]) free_id = k;
                exp_rr = !m_apend && (free_id >= 0) && (q.size() < NID);
                exp_rv = (q.size() > 0) && m_got[q[0]];

                chk("rnd_req_ready",  64'(bus.req_ready), 64'(exp_rr));
                chk("rnd_a_valid",    64'(bus.a_valid), 64'(m_apend));
                chk("rnd_resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
                chk("rnd_proto_err",  64'(bus.proto_err), 64'(m_perr));
                if (m_apend)
                    chk("rnd_a_beat",
                        64'({bus.a_opcode, bus.a_source, bus.a_address, bus.a_mask, bus.a_data}),
                        64'(m_abeat));
                if (exp_rv) begin
                    chk("rnd_resp_data",  64'(bus.resp_data), 64'(m_rdata[q[0]]));
                    chk("rnd_resp_error", 64'(bus.resp_error), 64'(m_rerr[q[0]]));
                end

                bus.req_valid  = 1'($urandom_range(0, 1));
                bus.req_write  = 1'($urandom_range(0, 1));
                bus.req_addr   = AB'($urandom_range(0, 127)) << 2;
                bus.req_data   = DB'($urandom);
                bus.req_mask   = MB'($urandom);
                bus.a_ready    = 1'($urandom_range(0, 1));
                bus.resp_ready = 1'($urandom_range(0, 1));
                bus.d_valid    = 1'b0;
                bus.d_denied   = 1'b0;
                bus.d_corrupt  = 1'b0;
                bus.d_sink     = KB'($urandom);
                bus.d_data     = DB'($urandom);
                cand.delete();
                for (int k = 0; k < NID; k++) if (m_busy[k] && !m_got[k]) cand.push_back(k);
                if (round > 0 && $urandom_range(0, 39) == 0) begin
                    bus.d_valid  = 1'b1;
                    bus.d_source = SB'($urandom_range(0, NID - 1));
                    bus.d_opcode = 3'($urandom_range(0, 7));
                end else if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                    ds = cand[$urandom_range(0, cand.size() - 1)];
                    bus.d_valid   = 1'b1;
                    bus.d_source  = SB'(ds);
                    bus.d_opcode  = m_wr[ds] ? ACK : ACK_DATA;
                    bus.d_denied  = ($urandom_range(0, 7) == 0);
                    bus.d_corrupt = ($urandom_range(0, 7) == 0);
                end

                acc  = bus.req_valid && exp_rr;
                fire = m_apend && bus.a_ready;
                pop  = exp_rv && bus.resp_ready;
                if (bus.d_valid) begin
                    ds = int'(bus.d_source);
                    legal = m_busy[ds] && !m_got[ds] && (bus.d_opcode == ACK || bus.d_opcode == ACK_DATA);
                    if (legal) begin
                        m_got[ds]   = 1'b1;
                        m_rdata[ds] = (bus.d_opcode == ACK_DATA) ? bus.d_data : '0;
                        m_rerr[ds]  = bus.d_denied | bus.d_corrupt;
                    end else begin
                        m_perr = 1'b1;
                    end
                end
                if (pop) begin
                    h = q.pop_front();
                    m_busy[h] = 1'b0;
                    m_got[h]  = 1'b0;
                end
                if (fire) m_apend = 1'b0;
                if (acc) begin
                    m_busy[free_id] = 1'b1;
                    m_wr[free_id]   = bus.req_write;
                    q.push_back(free_id);
                    m_apend = 1'b1;
                    m_abeat = {(bus.req_write ? PUT_FULL : GET), SB'(free_id), bus.req_addr,
                               (bus.req_write ? bus.req_mask : 4'hF),
                               (bus.req_write ? bus.req_data : 32'h0)};
                end
                tick();
            end
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
